// File: rtl/pw_candidate_gen.sv
`default_nettype none
// ============================================================================
// Module   : pw_candidate_gen
// Purpose  : Brute-force password candidate source. Enumerates every
//            PW_LEN-character word over a 36-symbol alphabet (A-Z, 0-9)
//            whose first character index lies in [from..to], and streams
//            the words out on a valid/ready interface.
// Options  : HIT_STOP_EN - when defined, a comparator hit in EMIT ends the
//            run early and reports found_stop_o together with done_o.
// Revision : 1.0 - initial release
// ============================================================================
module pw_candidate_gen #(
  parameter int PW_LEN  = 4,
  parameter int CHARSET = 36,
  parameter int IDX_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [IDX_W-1:0]    from_i,
  input  logic [IDX_W-1:0]    to_i,
  input  logic                abort_i,
  input  logic                hit_i,
  output logic [PW_LEN*8-1:0] cand_o,
  output logic                cand_valid_o,
  input  logic                cand_ready_i,
  output logic                cand_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                range_err_o
`ifdef HIT_STOP_EN
  ,
  output logic                found_stop_o
`endif
);

  // Highest legal per-character index; a first-character end index above
  // this value is outside the alphabet.
  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(CHARSET - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EMIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] from_q, from_d;
  logic [IDX_W-1:0] to_q, to_d;
  logic [IDX_W-1:0] idx_q [PW_LEN];
  logic [IDX_W-1:0] idx_d [PW_LEN];
  logic             range_err_q, range_err_d;

  logic [IDX_W-1:0] w_idx_inc [PW_LEN];
  logic             w_carry;
  logic             w_rest_max;
  logic             w_range_bad;
  logic             w_emit;
  logic             w_hs;
  logic             w_last;
  logic [PW_LEN*8-1:0] w_cand_map;

`ifdef HIT_STOP_EN
  logic             found_stop_q, found_stop_d;
`else
  // Without early stop the comparator hit has no effect on enumeration.
  logic             unused_hit;
  assign unused_hit = hit_i;
`endif

  // Map a character index to its ASCII code: 0-25 -> 'A'-'Z', 26-35 -> '0'-'9'.
  function automatic logic [7:0] f_ascii(input logic [IDX_W-1:0] idx);
    logic [7:0] v;
    v = 8'(idx);
    if (v < 8'd26) begin
      f_ascii = 8'h41 + v;
    end else begin
      f_ascii = 8'h30 + (v - 8'd26);
    end
  endfunction

  // Position 0 is the leftmost character and occupies the MSB byte.
  generate
    for (genvar g = 0; g < PW_LEN; g++) begin : g_cand_map
      assign w_cand_map[(PW_LEN-1-g)*8 +: 8] = f_ascii(idx_q[g]);
    end
  endgenerate

  assign w_emit      = (state_q == S_EMIT);
  assign w_hs        = w_emit && cand_ready_i;
  assign w_range_bad = (from_q > to_q) || (to_q > C_IDX_MAX);

  // Odometer increment: rightmost position first, each wrapping to 0 and
  // carrying left. Position 0 never wraps because the run ends at 'to'.
  always_comb begin
    w_idx_inc = idx_q;
    w_carry   = 1'b1;
    for (int i = PW_LEN - 1; i >= 1; i--) begin
      if (w_carry) begin
        if (idx_q[i] == C_IDX_MAX) begin
          w_idx_inc[i] = '0;
        end else begin
          w_idx_inc[i] = idx_q[i] + 1'b1;
          w_carry      = 1'b0;
        end
      end
    end
    if (w_carry) begin
      w_idx_inc[0] = idx_q[0] + 1'b1;
    end
  end

  // Detect that every non-leading position sits at the top of the alphabet.
  always_comb begin
    w_rest_max = 1'b1;
    for (int i = 1; i < PW_LEN; i++) begin
      if (idx_q[i] != C_IDX_MAX) begin
        w_rest_max = 1'b0;
      end
    end
  end

  assign w_last = w_emit && (idx_q[0] == to_q) && w_rest_max;

  // Next-state logic: sequencing, range check, counter advance, abort/stop.
  always_comb begin
    state_d     = state_q;
    from_d      = from_q;
    to_d        = to_q;
    idx_d       = idx_q;
    range_err_d = 1'b0;
`ifdef HIT_STOP_EN
    found_stop_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          from_d  = from_i;
          to_d    = to_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort_i) begin
          state_d = S_FIN;
        end else if (w_range_bad) begin
          range_err_d = 1'b1;
          state_d     = S_FIN;
        end else begin
          idx_d[0] = from_q;
          for (int i = 1; i < PW_LEN; i++) begin
            idx_d[i] = '0;
          end
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // abort outranks a concurrent handshake: the counter is frozen.
        if (abort_i) begin
          state_d = S_FIN;
`ifdef HIT_STOP_EN
        end else if (hit_i) begin
          found_stop_d = 1'b1;
          state_d      = S_FIN;
`endif
        end else if (w_hs) begin
          if (w_last) begin
            state_d = S_FIN;
          end else begin
            idx_d = w_idx_inc;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      from_q      <= '0;
      to_q        <= '0;
      range_err_q <= 1'b0;
      for (int i = 0; i < PW_LEN; i++) begin
        idx_q[i] <= '0;
      end
`ifdef HIT_STOP_EN
      found_stop_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      from_q      <= from_d;
      to_q        <= to_d;
      range_err_q <= range_err_d;
      idx_q       <= idx_d;
`ifdef HIT_STOP_EN
      found_stop_q <= found_stop_d;
`endif
    end
  end

  // Outputs decode the registered state; cand reads zero outside EMIT.
  assign cand_valid_o = w_emit;
  assign cand_o       = w_emit ? w_cand_map : '0;
  assign cand_last_o  = w_last;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FIN);
  assign range_err_o  = range_err_q;
`ifdef HIT_STOP_EN
  assign found_stop_o = found_stop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pw_candidate_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_candidate_gen
// Purpose  : Self-checking bench for pw_candidate_gen. Two instances
//            (PW_LEN=2 and PW_LEN=4) share stimulus; a vector table drives
//            runs and a queue of expected candidates is checked at every
//            handshake. Honours HIT_STOP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_candidate_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start2 = 1'b0, start4 = 1'b0;
  logic [5:0]  from_s = '0, to_s = '0;
  logic        abort_s = 1'b0, hit_s = 1'b0, ready_s = 1'b0;
  bit          sel4 = 1'b0;

  logic [15:0] cand2;
  logic [31:0] cand4;
  logic        valid2, last2, busy2, done2, rerr2;
  logic        valid4, last4, busy4, done4, rerr4;
`ifdef HIT_STOP_EN
  logic        fstop2, fstop4;
`endif

  always #5 clk = ~clk;

  pw_candidate_gen #(.PW_LEN(2), .CHARSET(36), .IDX_W(6)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .from_i(from_s), .to_i(to_s),
    .abort_i(abort_s), .hit_i(hit_s), .cand_o(cand2), .cand_valid_o(valid2),
    .cand_ready_i(ready_s), .cand_last_o(last2), .busy_o(busy2),
    .done_o(done2), .range_err_o(rerr2)
`ifdef HIT_STOP_EN
    , .found_stop_o(fstop2)
`endif
  );

  pw_candidate_gen #(.PW_LEN(4), .CHARSET(36), .IDX_W(6)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .from_i(from_s), .to_i(to_s),
    .abort_i(abort_s), .hit_i(hit_s), .cand_o(cand4), .cand_valid_o(valid4),
    .cand_ready_i(ready_s), .cand_last_o(last4), .busy_o(busy4),
    .done_o(done4), .range_err_o(rerr4)
`ifdef HIT_STOP_EN
    , .found_stop_o(fstop4)
`endif
  );

  // Monitor view of whichever instance is under test.
  logic [63:0] m_cand;
  logic        m_valid, m_last, m_busy, m_done, m_rerr, m_fstop;
  always_comb begin
    m_cand  = sel4 ? {32'b0, cand4} : {48'b0, cand2};
    m_valid = sel4 ? valid4 : valid2;
    m_last  = sel4 ? last4  : last2;
    m_busy  = sel4 ? busy4  : busy2;
    m_done  = sel4 ? done4  : done2;
    m_rerr  = sel4 ? rerr4  : rerr2;
`ifdef HIT_STOP_EN
    m_fstop = sel4 ? fstop4 : fstop2;
`else
    m_fstop = 1'b0;
`endif
  end

  typedef struct {
    bit sel4;
    int from;
    int to;
    int rmode;        // 0: ready held high, 1: ready toggles each cycle
    int abort_after;  // abort once this many handshakes are done, -1 never
    int hit_at;       // pulse hit on the handshake with this index, -1 never
    int exp_n;        // candidates expected to be accepted
    bit rerr;
    bit fstop;
  } vec_t;

  typedef struct {
    logic [63:0] cand;
    logic        last;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the n-th word of the run, from a base-36 decomposition of n.
  function automatic logic [63:0] model_cand(int len, int from, int n);
    logic [63:0] v;
    int rem;
    int d;
    v   = '0;
    rem = n;
    for (int p = len - 1; p >= 0; p--) begin
      if (p == 0) begin
        d = from + rem;
      end else begin
        d   = rem % 36;
        rem = rem / 36;
      end
      v[(len-1-p)*8 +: 8] = (d < 26) ? 8'(65 + d) : 8'(48 + d - 26);
    end
    return v;
  endfunction

  function automatic int f_total(int len, int from, int to);
    int r;
    r = to - from + 1;
    for (int i = 1; i < len; i++) r = r * 36;
    return r;
  endfunction

  task automatic run(input vec_t v);
    int len, total, hs, cyc, bound;
    bit done_next, seen_done, rtog, prev_stall, abort_now, rdy, hit_now;
    logic [63:0] prev_cand;
    exp_t e;
    len = v.sel4 ? 4 : 2;
    total = f_total(len, v.from, v.to);
    q_exp.delete();
    for (int n = 0; n < v.exp_n; n++) begin
      e.cand = model_cand(len, v.from, n);
      e.last = (n == total - 1);
      q_exp.push_back(e);
    end
    hs = 0; cyc = 0; bound = 3 * v.exp_n + 20;
    done_next = 0; seen_done = 0; rtog = 0; prev_stall = 0; prev_cand = '0;

    @(negedge clk);
    sel4 = v.sel4; from_s = 6'(v.from); to_s = 6'(v.to); ready_s = 0;
    if (v.sel4) start4 = 1; else start2 = 1;
    @(negedge clk);
    start2 = 0; start4 = 0;
    chk("busy_after_start", {63'b0, m_busy}, 64'd1);
    chk("no_valid_in_check", {63'b0, m_valid}, 64'd0);

    while (!seen_done && cyc < bound) begin
      if (cyc == 1 && v.exp_n > 0) chk("first_valid", {63'b0, m_valid}, 64'd1);
      if (done_next) chk("done_timing", {63'b0, m_done}, 64'd1);
      if (m_done) begin
        seen_done = 1;
        chk("done_expected_now", {63'b0, (done_next || (v.exp_n == 0 && cyc == 1))}, 64'd1);
        break;
      end
      if (prev_stall && m_valid) chk("stable_while_stalled", m_cand, prev_cand);

      abort_now = (v.abort_after >= 0) && (hs == v.abort_after);
      rdy       = abort_now ? 1'b0 : ((v.rmode == 0) ? 1'b1 : rtog);
      hit_now   = (v.hit_at >= 0) && m_valid && rdy && (hs == v.hit_at);
      abort_s = abort_now; ready_s = rdy; hit_s = hit_now;
      if (abort_now) done_next = 1;
`ifdef HIT_STOP_EN
      if (hit_now) done_next = 1;
`endif
      if (m_valid && rdy) begin
        if (q_exp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_cand: got %0h, expected none", m_cand);
        end else begin
          e = q_exp.pop_front();
          chk("cand", m_cand, e.cand);
          chk("cand_last", {63'b0, m_last}, {63'b0, e.last});
          if (e.last) done_next = 1;
        end
        hs++;
      end
      prev_stall = m_valid && !rdy;
      prev_cand  = m_cand;
      rtog = ~rtog;
      @(negedge clk);
      abort_s = 0; hit_s = 0;
      cyc++;
    end
    ready_s = 0; abort_s = 0; hit_s = 0;

    if (!seen_done) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: got no done, expected done within %0d cycles", bound);
    end else begin
      chk("valid_low_at_done", {63'b0, m_valid}, 64'd0);
      chk("range_err", {63'b0, m_rerr}, {63'b0, v.rerr});
`ifdef HIT_STOP_EN
      chk("found_stop", {63'b0, m_fstop}, {63'b0, v.fstop});
`endif
      chk("accepted_count", 64'(hs), 64'(v.exp_n));
      chk("missing_cands", 64'(q_exp.size()), 64'd0);
      @(negedge clk);
      chk("idle_busy", {63'b0, m_busy}, 64'd0);
      chk("done_one_cycle", {63'b0, m_done}, 64'd0);
      chk("range_err_cleared", {63'b0, m_rerr}, 64'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    // PW_LEN=2 full single-letter range, ready high.
    vecs[0] = '{1'b0, 0, 0, 0, -1, -1, 36, 1'b0, 1'b0};
    // PW_LEN=2 "8A".."99" with ready toggling.
    vecs[1] = '{1'b0, 34, 35, 1, -1, -1, 72, 1'b0, 1'b0};
    // Illegal ranges: from>to, and to beyond the alphabet.
    vecs[2] = '{1'b0, 5, 3, 0, -1, -1, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 5, 36, 0, -1, -1, 0, 1'b1, 1'b0};
    // Abort during CHECK with an illegal range: no range error reported.
    vecs[4] = '{1'b0, 5, 3, 0, 0, -1, 0, 1'b0, 1'b0};
    // Last letter only, ready toggling, ends on "99".
    vecs[5] = '{1'b0, 35, 35, 1, -1, -1, 36, 1'b0, 1'b0};
    // PW_LEN=4 abort after the 10th handshake.
    vecs[6] = '{1'b1, 0, 35, 0, 10, -1, 10, 1'b0, 1'b0};
    // PW_LEN=4 long run crossing a carry into the third position.
    vecs[7] = '{1'b1, 0, 0, 0, 1300, -1, 1300, 1'b0, 1'b0};
    // Hit pulsed on "AD".
`ifdef HIT_STOP_EN
    vecs[8] = '{1'b0, 0, 0, 0, -1, 3, 4, 1'b0, 1'b1};
`else
    vecs[8] = '{1'b0, 0, 0, 0, -1, 3, 36, 1'b0, 1'b0};
`endif
    // Legal edge case: to == CHARSET-1 with from == to on PW_LEN=4, aborted.
    vecs[9] = '{1'b1, 35, 35, 1, 40, -1, 40, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid2", {63'b0, valid2}, 64'd0);
    chk("rst_cand4", {32'b0, cand4}, 64'd0);
    chk("rst_busy4", {63'b0, busy4}, 64'd0);
    chk("rst_done2", {63'b0, done2}, 64'd0);
    chk("rst_rerr4", {63'b0, rerr4}, 64'd0);
    rst = 0;

    // Start while busy must be ignored: re-pulse start during vector 0 is
    // not exercised here; instead each vector runs from IDLE.
    for (int i = 0; i < 10; i++) run(vecs[i]);

    // Reset mid-EMIT on the PW_LEN=4 instance.
    @(negedge clk);
    sel4 = 1; from_s = 6'd0; to_s = 6'd35; start4 = 1;
    @(negedge clk);
    start4 = 0; ready_s = 1;
    repeat (6) @(negedge clk);
    chk("pre_rst_valid", {63'b0, m_valid}, 64'd1);
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", {63'b0, m_valid}, 64'd0);
    chk("midrst_cand", m_cand, 64'd0);
    chk("midrst_last", {63'b0, m_last}, 64'd0);
    chk("midrst_busy", {63'b0, m_busy}, 64'd0);
    chk("midrst_done", {63'b0, m_done}, 64'd0);
    chk("midrst_rerr", {63'b0, m_rerr}, 64'd0);
    rst = 0; ready_s = 0;
    @(negedge clk);
    chk("postrst_no_done", {63'b0, m_done}, 64'd0);
    // Restart must begin at "AAAA".
    run('{1'b1, 0, 35, 0, 3, -1, 3, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no end of test, expected finish before %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
